// File: rtl/i2c_byte_ctrl_if.sv
// -----------------------------------------------------------------------------
// i2c_byte_ctrl_if
// Bundle of host-side, bit-controller-side and byte-timer signals around the
// I2C byte controller.
//
// Handshakes (both levels, no data loss on stalls):
//   host  -> ctrl : Start/Stop/Read/Write are levels held by the host until
//                   Cmd_Ack pulses for one cycle; Din/Ack_In must be stable
//                   over that whole window.
//   ctrl  -> bit  : Bit_Cmd/Bit_Din are held constant until the bit
//                   controller pulses Bit_Ack for one cycle; Bit_Dout is valid
//                   in that cycle only. Al aborts whatever is in flight.
//
// Modports:
//   slave  - the byte controller itself
//   master - the environment (host, bit controller, byte timer)
// Dbg_State exposes the controller FSM state encoding for checkers.
// -----------------------------------------------------------------------------
interface i2c_byte_ctrl_if #(
    parameter int DW = 8
);
    // host command side
    logic          Start;
    logic          Stop;
    logic          Read;
    logic          Write;
    logic          Ack_In;
    logic [DW-1:0] Din;
    logic          Cmd_Ack;
    logic          Ack_Out;
    logic [DW-1:0] Dout;
    logic          Busy;
    // bit controller side
    logic [2:0]    Bit_Cmd;
    logic          Bit_Din;
    logic          Bit_Ack;
    logic          Bit_Dout;
    logic          Al;
    // external byte timer
    logic          Cnt_Load;
    logic          Cnt_Dec;
    logic          Cnt_Zero;
    // debug
    logic [2:0]    Dbg_State;

    modport slave (
        input  Start, Stop, Read, Write, Ack_In, Din,
        output Cmd_Ack, Ack_Out, Dout, Busy,
        output Bit_Cmd, Bit_Din,
        input  Bit_Ack, Bit_Dout, Al,
        output Cnt_Load, Cnt_Dec,
        input  Cnt_Zero,
        output Dbg_State
    );

    modport master (
        output Start, Stop, Read, Write, Ack_In, Din,
        input  Cmd_Ack, Ack_Out, Dout, Busy,
        input  Bit_Cmd, Bit_Din,
        output Bit_Ack, Bit_Dout, Al,
        input  Cnt_Load, Cnt_Dec,
        output Cnt_Zero,
        input  Dbg_State
    );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_byte_ctrl
// Byte-level controller of an I2C master. Turns host byte commands
// (START / WRITE / READ / STOP) into a sequence of single bit commands for the
// bit-level controller, shifts the data byte out/in MSB first, handles the
// 9th (ACK) bit and drives an external count-down timer that marks the last
// data bit of a byte.
//
// Ports:
//   Clk    clock
//   Rst_n  asynchronous reset, active low
//   bus    i2c_byte_ctrl_if.slave:
//            host    Start/Stop/Read/Write/Ack_In/Din in, Cmd_Ack/Ack_Out/
//                    Dout/Busy out
//            bit     Bit_Cmd/Bit_Din out, Bit_Ack/Bit_Dout/Al in
//            timer   Cnt_Load/Cnt_Dec out, Cnt_Zero in (timer loads DW-1)
//            debug   Dbg_State out (FSM state)
// -----------------------------------------------------------------------------
module i2c_byte_ctrl #(
    parameter int DW = 8
) (
    input logic            Clk,
    input logic            Rst_n,
    i2c_byte_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_ACK   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    localparam logic [2:0] BC_NOP   = 3'b000;
    localparam logic [2:0] BC_START = 3'b001;
    localparam logic [2:0] BC_STOP  = 3'b010;
    localparam logic [2:0] BC_WRITE = 3'b011;
    localparam logic [2:0] BC_READ  = 3'b100;

    state_t        state_q, state_d;
    logic [2:0]    bit_cmd_q, bit_cmd_d;
    logic          bit_din_q, bit_din_d;
    logic          cmd_ack_q, cmd_ack_d;
    logic          ack_out_q, ack_out_d;
    logic          cnt_load_q, cnt_load_d;
    logic          was_read_q, was_read_d;
    logic [DW-1:0] sr_q, sr_d;
    logic [DW-1:0] sr_shift;
    logic          any_cmd;

    assign any_cmd  = bus.Start | bus.Stop | bus.Read | bus.Write;
    assign sr_shift = {sr_q[DW-2:0], bus.Bit_Dout};

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            bit_cmd_q  <= BC_NOP;
            bit_din_q  <= 1'b0;
            cmd_ack_q  <= 1'b0;
            ack_out_q  <= 1'b0;
            cnt_load_q <= 1'b0;
            was_read_q <= 1'b0;
            sr_q       <= '0;
        end else begin
            state_q    <= state_d;
            bit_cmd_q  <= bit_cmd_d;
            bit_din_q  <= bit_din_d;
            cmd_ack_q  <= cmd_ack_d;
            ack_out_q  <= ack_out_d;
            cnt_load_q <= cnt_load_d;
            was_read_q <= was_read_d;
            sr_q       <= sr_d;
        end
    end

    // Next state and next registered outputs. Bit_Cmd is computed together
    // with the state so both change on the same edge.
    always_comb begin
        state_d    = state_q;
        bit_cmd_d  = bit_cmd_q;
        bit_din_d  = bit_din_q;
        cmd_ack_d  = 1'b0;
        ack_out_d  = ack_out_q;
        cnt_load_d = 1'b0;
        was_read_d = was_read_q;
        sr_d       = sr_q;

        if (bus.Al) begin
            // Arbitration lost wins over everything, including a Bit_Ack in
            // the same cycle: drop to IDLE silently, keep Dout/Ack_Out.
            state_d   = S_IDLE;
            bit_cmd_d = BC_NOP;
            bit_din_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Cmd_Ack is still high in the first IDLE cycle while the
                    // host drops its level; that cycle must not restart.
                    if (!cmd_ack_q && any_cmd) begin
                        sr_d       = bus.Din;
                        cnt_load_d = 1'b1;
                        if (bus.Start) begin
                            state_d   = S_START;
                            bit_cmd_d = BC_START;
                        end else if (bus.Read) begin
                            state_d   = S_READ;
                            bit_cmd_d = BC_READ;
                            bit_din_d = bus.Din[DW-1];
                        end else if (bus.Write) begin
                            state_d   = S_WRITE;
                            bit_cmd_d = BC_WRITE;
                            bit_din_d = bus.Din[DW-1];
                        end else begin
                            state_d   = S_STOP;
                            bit_cmd_d = BC_STOP;
                        end
                    end
                end

                S_START: begin
                    if (bus.Bit_Ack) begin
                        // Reload the timer: the data phase starts now.
                        cnt_load_d = 1'b1;
                        bit_din_d  = sr_q[DW-1];
                        if (bus.Read) begin
                            state_d   = S_READ;
                            bit_cmd_d = BC_READ;
                        end else begin
                            state_d   = S_WRITE;
                            bit_cmd_d = BC_WRITE;
                        end
                    end
                end

                S_WRITE, S_READ: begin
                    if (bus.Bit_Ack) begin
                        sr_d = sr_shift;
                        if (bus.Cnt_Zero) begin
                            // 8th data bit done: the ACK bit goes the other way.
                            state_d    = S_ACK;
                            was_read_d = (state_q == S_READ);
                            if (state_q == S_READ) begin
                                bit_cmd_d = BC_WRITE;
                                bit_din_d = bus.Ack_In;
                            end else begin
                                bit_cmd_d = BC_READ;
                                bit_din_d = 1'b1;
                            end
                        end else begin
                            bit_din_d = sr_shift[DW-1];
                        end
                    end
                end

                S_ACK: begin
                    if (bus.Bit_Ack) begin
                        if (!was_read_q) begin
                            ack_out_d = bus.Bit_Dout;
                        end
                        if (bus.Stop) begin
                            state_d   = S_STOP;
                            bit_cmd_d = BC_STOP;
                            bit_din_d = 1'b0;
                        end else begin
                            state_d   = S_IDLE;
                            bit_cmd_d = BC_NOP;
                            bit_din_d = 1'b0;
                            cmd_ack_d = 1'b1;
                        end
                    end
                end

                S_STOP: begin
                    if (bus.Bit_Ack) begin
                        state_d   = S_IDLE;
                        bit_cmd_d = BC_NOP;
                        bit_din_d = 1'b0;
                        cmd_ack_d = 1'b1;
                    end
                end

                default: begin
                    state_d   = S_IDLE;
                    bit_cmd_d = BC_NOP;
                    bit_din_d = 1'b0;
                end
            endcase
        end
    end

    // The acknowledge of the last data bit does not decrement: the timer is
    // already at zero and is reloaded for the next byte.
    assign bus.Cnt_Dec   = bus.Bit_Ack & ((state_q == S_WRITE) | (state_q == S_READ))
                           & ~bus.Cnt_Zero;
    assign bus.Cnt_Load  = cnt_load_q;
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Bit_Cmd   = bit_cmd_q;
    assign bus.Bit_Din   = bit_din_q;
    assign bus.Cmd_Ack   = cmd_ack_q;
    assign bus.Ack_Out   = ack_out_q;
    assign bus.Dout      = sr_q;
    assign bus.Dbg_State = state_q;

endmodule
